// File: rtl/mem_stage_ctrl_if.sv
// EXE->MEM stage bundle: pipeline inputs from EXE, stage outputs towards MEM/WB and the stall line.
// master = EXE-side driver, slave = the memory-stage controller.
interface mem_stage_ctrl_if;
    logic        wb_en_in;
    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic [31:0] alu_result;
    logic [31:0] val_rm;
    logic [3:0]  dest_in;
    logic        wb_en;
    logic        mem_r_en;
    logic [31:0] alu_result_out;
    logic [3:0]  dest;
    logic [31:0] mem_data;
    logic        ready;

    modport master (
        output wb_en_in, mem_r_en_in, mem_w_en_in, alu_result, val_rm, dest_in,
        input  wb_en, mem_r_en, alu_result_out, dest, mem_data, ready
    );

    modport slave (
        input  wb_en_in, mem_r_en_in, mem_w_en_in, alu_result, val_rm, dest_in,
        output wb_en, mem_r_en, alu_result_out, dest, mem_data, ready
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage with a fixed-latency data memory: a memory op stalls LATENCY+1 cycles, then 1 ready cycle.
// Backpressure: ready=0 freezes upstream; non-memory ops pass through with zero stall.
module mem_stage_ctrl #(
    parameter int unsigned LATENCY    = 3,
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned BASE_ADDR  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    mem_stage_ctrl_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [31:0] BASE  = 32'(BASE_ADDR);
    localparam logic [32:0] LIMIT = 33'(BASE_ADDR) + 33'(4 * DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [31:0]             mem_data_q, mem_data_d;
    logic [31:0]             mem_q [DEPTH];
    logic                    mem_we;
    logic                    req;
    logic                    in_range;
    logic [DEPTH_LOG2-1:0]   idx;

    assign req      = bus.mem_r_en_in | bus.mem_w_en_in;
    assign idx      = DEPTH_LOG2'((bus.alu_result - BASE) >> 2);
    assign in_range = (bus.alu_result >= BASE) && ({1'b0, bus.alu_result} < LIMIT);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_data_d = mem_data_q;
        mem_we     = 1'b0;
        if (rst) begin
            state_d    = S_IDLE;
            cnt_d      = 4'd0;
            mem_data_d = 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = S_DONE;
                        // A store wins when both enables are set; mem_data is left alone.
                        if (bus.mem_w_en_in)
                            mem_we = in_range;
                        else if (bus.mem_r_en_in)
                            mem_data_d = in_range ? mem_q[idx] : 32'd0;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        mem_data_q <= mem_data_d;
    end

    // Memory contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[idx] <= bus.val_rm;
    end

    // While reset is asserted the stage looks idle regardless of the registered state.
    assign bus.ready          = (rst || state_q == S_IDLE) ? !req : (state_q == S_DONE);
    assign bus.wb_en          = bus.wb_en_in & bus.ready;
    assign bus.mem_r_en       = bus.mem_r_en_in;
    assign bus.alu_result_out = bus.alu_result;
    assign bus.dest           = bus.dest_in;
    assign bus.mem_data       = mem_data_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed + random bench for mem_stage_ctrl against an array-based model of the data memory.
module tb_mem_stage_ctrl;
    localparam int unsigned LAT   = 3;
    localparam int unsigned BASE  = 1024;
    localparam int unsigned WORDS = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_stage_ctrl_if bus ();

    mem_stage_ctrl #(.LATENCY(LAT), .DEPTH_LOG2(6), .BASE_ADDR(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [31:0] model_mem [WORDS];
    logic [31:0] model_md = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_in_range(input logic [31:0] a);
        return (a >= BASE) && (longint'(a) < longint'(BASE) + 4 * WORDS);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'(((a - BASE) / 4) % WORDS);
    endfunction

    task automatic drive(input logic r, input logic w, input logic wbi,
                         input logic [31:0] addr, input logic [31:0] val, input logic [3:0] d);
        bus.mem_r_en_in = r;
        bus.mem_w_en_in = w;
        bus.wb_en_in    = wbi;
        bus.alu_result  = addr;
        bus.val_rm      = val;
        bus.dest_in     = d;
    endtask

    // Entered shortly after a rising edge; returns shortly after the edge that retires the instruction.
    task automatic run_instr(input string tag, input logic r, input logic w, input logic wbi,
                             input logic [31:0] addr, input logic [31:0] val, input logic [3:0] d);
        logic [31:0] old_md;
        int          n;
        bit          exp_rdy;
        drive(r, w, wbi, addr, val, d);
        old_md = model_md;
        n = (r || w) ? int'(LAT) + 2 : 1;
        if (w) begin
            if (addr_in_range(addr)) model_mem[word_of(addr)] = val;
        end else if (r) begin
            model_md = addr_in_range(addr) ? model_mem[word_of(addr)] : 32'd0;
        end
        for (int k = 0; k < n; k++) begin
            #1;
            exp_rdy = (k == n - 1);
            chk({tag, ".ready"}, 32'(bus.ready), 32'(exp_rdy));
            chk({tag, ".wb_en"}, 32'(bus.wb_en), 32'(wbi & exp_rdy));
            chk({tag, ".alu_out"}, bus.alu_result_out, addr);
            chk({tag, ".dest"}, 32'(bus.dest), 32'(d));
            chk({tag, ".mem_r_en"}, 32'(bus.mem_r_en), 32'(r));
            chk({tag, ".mem_data"}, bus.mem_data, exp_rdy ? model_md : old_md);
            @(posedge clk);
            #1;
        end
    endtask

    // Starts a store, then pulses reset in its second wait cycle; no model update happens.
    task automatic run_abort(input string tag, input logic [31:0] addr, input logic [31:0] val);
        drive(1'b0, 1'b1, 1'b1, addr, val, 4'd2);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk({tag, ".pre_rdy"}, 32'(bus.ready), 32'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk({tag, ".rst_rdy"}, 32'(bus.ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_md = 32'd0;
        #1;
        chk({tag, ".md_cleared"}, bus.mem_data, 32'd0);
        chk({tag, ".idle_rdy"}, 32'(bus.ready), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] v;
        int          sel;

        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.mem_data", bus.mem_data, 32'd0);
        chk("reset.ready", 32'(bus.ready), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset.ready", 32'(bus.ready), 32'd1);

        // Fill every word so the model starts fully defined.
        for (int i = 0; i < int'(WORDS); i++)
            run_instr("fill", 1'b0, 1'b1, 1'b0, 32'(BASE + 4 * i), $urandom, 4'(i));

        run_instr("st1028", 1'b0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 4'd1);
        run_instr("ld1028", 1'b1, 1'b0, 1'b1, 32'd1028, 32'd0, 4'd3);

        for (int i = 0; i < 5; i++)
            run_instr("alu_pass", 1'b0, 1'b0, 1'b1, $urandom, 32'd0, 4'($urandom_range(0, 15)));

        run_instr("st_1028b", 1'b0, 1'b1, 1'b0, 32'd1028, 32'h12345678, 4'd0);
        run_instr("ld_1030", 1'b1, 1'b0, 1'b1, 32'd1030, 32'd0, 4'd4);

        run_instr("ld_oor", 1'b1, 1'b0, 1'b1, 32'h10, 32'd0, 4'd5);
        run_instr("st_oor", 1'b0, 1'b1, 1'b0, 32'h10, 32'hCAFEF00D, 4'd5);
        run_instr("ld_1023", 1'b1, 1'b0, 1'b1, 32'd1023, 32'd0, 4'd6);
        run_instr("st_1280", 1'b0, 1'b1, 1'b0, 32'd1280, 32'h0BADF00D, 4'd6);
        run_instr("ld_1276", 1'b1, 1'b0, 1'b1, 32'd1276, 32'd0, 4'd7);
        for (int i = 0; i < int'(WORDS); i++)
            run_instr("sweep", 1'b1, 1'b0, 1'b1, 32'(BASE + 4 * i), 32'd0, 4'd8);

        run_abort("abort_a", 32'd1032, 32'hAAAA5555);
        run_instr("ld_after_abort", 1'b1, 1'b0, 1'b1, 32'd1032, 32'd0, 4'd2);
        run_abort("abort_b", 32'd1032, 32'h5555AAAA);
        run_instr("st_restart", 1'b0, 1'b1, 1'b1, 32'd1032, 32'h5555AAAA, 4'd2);
        run_instr("ld_restart", 1'b1, 1'b0, 1'b1, 32'd1032, 32'd0, 4'd2);

        run_instr("b2b_st", 1'b0, 1'b1, 1'b1, 32'd1036, 32'h0F0F1234, 4'd9);
        run_instr("b2b_ld", 1'b1, 1'b0, 1'b1, 32'd1036, 32'd0, 4'd9);

        run_instr("both_en", 1'b1, 1'b1, 1'b1, 32'd1040, 32'h77778888, 4'd10);
        run_instr("ld_both", 1'b1, 1'b0, 1'b1, 32'd1040, 32'd0, 4'd10);

        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7) a = 32'(BASE) + 32'($urandom_range(0, 4 * WORDS - 1));
            else if (sel == 7) a = 32'(BASE + 4 * WORDS) + 32'($urandom_range(0, 64));
            else a = $urandom;
            v = $urandom;
            case ($urandom_range(0, 3))
                0:       run_instr("rnd_alu", 1'b0, 1'b0, 1'($urandom), a, v, 4'($urandom));
                1:       run_instr("rnd_st", 1'b0, 1'b1, 1'($urandom), a, v, 4'($urandom));
                2:       run_instr("rnd_ld", 1'b1, 1'b0, 1'($urandom), a, v, 4'($urandom));
                default: run_instr("rnd_both", 1'b1, 1'b1, 1'($urandom), a, v, 4'($urandom));
            endcase
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter LATENCY, default 3: wait cycles per data-memory access; legal range 1..15.
REQ-002 Parameter DEPTH_LOG2, default 6: log2 of the number of 32-bit data-memory words (default 64 words).
REQ-003 Parameter BASE_ADDR, default 1024: byte address of data-memory word 0.
REQ-004 clk  input  1  single clock; every register updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 wb_en_in  input  1  write-back enable from the EXE stage.
REQ-007 mem_r_en_in  input  1  load request from the EXE stage.
REQ-008 mem_w_en_in  input  1  store request from the EXE stage.
REQ-009 alu_result  input  32  effective byte address, or the ALU value for non-memory instructions.
REQ-010 val_rm  input  32  store data.
REQ-011 dest_in  input  4  destination register number.
REQ-012 wb_en  output  1  write-back enable to MEM/WB, equal to wb_en_in AND ready.
REQ-013 mem_r_en  output  1  mem_r_en_in passed through combinationally.
REQ-014 alu_result_out  output  32  alu_result passed through combinationally.
REQ-015 dest  output  4  dest_in passed through combinationally.
REQ-016 mem_data  output  32  registered data from the most recently completed load.
REQ-017 ready  output  1  combinational; 0 means the upstream pipeline registers shall freeze and hold their inputs.

Function
REQ-018 Signal req SHALL be defined as mem_r_en_in OR mem_w_en_in.
REQ-019 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-020 IDLE transitions: with req=1, go to WAIT and load cnt with LATENCY-1; with req=0, stay in IDLE.
REQ-021 WAIT with cnt not 0: decrement cnt and stay in WAIT.
REQ-022 WAIT with cnt=0: perform the access at that clock edge, then go to DONE.
REQ-023 DONE: go to IDLE unconditionally on the next edge.
REQ-024 ready SHALL be 1 in IDLE with req=0.
REQ-025 ready SHALL be 1 in DONE.
REQ-026 ready SHALL be 0 in IDLE with req=1 and in every WAIT cycle.
REQ-027 Per access, ready is low for LATENCY+1 cycles and high for 1 cycle (DONE), for LATENCY+2 cycles in total; upstream advances at the edge that ends DONE.
REQ-028 A non-memory instruction (req=0) SHALL pass through with zero stall.
REQ-029 Word index = (alu_result - BASE_ADDR) >> 2, truncated to DEPTH_LOG2 bits; address bits [1:0] are ignored.
REQ-030 In range means BASE_ADDR <= alu_result < BASE_ADDR + 4*2^DEPTH_LOG2, using unsigned 32-bit compare.
REQ-031 Store: mem[index] <= val_rm at the access edge; an out-of-range store is discarded.
REQ-032 Load: mem_data <= mem[index] at the access edge; an out-of-range load writes 0 into mem_data.
REQ-033 Out-of-range accesses SHALL use the same timing as in-range accesses.
REQ-034 If mem_r_en_in and mem_w_en_in are both 1, the store SHALL be performed and mem_data SHALL stay unchanged.
REQ-035 mem_data SHALL hold its value between loads; stores never change it.
REQ-036 Back-to-back memory instructions: after DONE the FSM returns to IDLE, and a new req asserts ready=0 in that same IDLE cycle, so there is no bubble and no lost request.
REQ-037 Inputs are sampled only at the access edge; changes to the inputs during WAIT are a protocol violation with undefined result.

Reset
REQ-038 With rst=1 at a clock edge: state <= IDLE, cnt <= 0, mem_data <= 0; memory contents are preserved.
REQ-039 During the rst=1 cycle, ready SHALL be driven as in IDLE, and combinational outputs SHALL follow the inputs.
REQ-040 Reset during WAIT SHALL abort the access with no store performed; if req is still 1 after reset, the access restarts from IDLE with full latency.

Verification (LATENCY=3, BASE_ADDR=1024)
REQ-041 Store 0xDEADBEEF to address 1028 -> ready=0 for 4 cycles, then 1 for 1 cycle; a following load from 1028 sets mem_data=0xDEADBEEF in its DONE cycle.
REQ-042 wb_en_in=1 with req=0 for 5 cycles -> ready=1 and wb_en=1 every cycle; alu_result_out and dest track the inputs with zero delay.
REQ-043 Load from address 1030 after a store of 0x12345678 to 1028 -> mem_data=0x12345678 (low address bits ignored).
REQ-044 Load from address 0x00000010 (out of range) -> same 5-cycle timing, mem_data=0; a store to 0x00000010 leaves every memory word unchanged.
REQ-045 Store to 1032 with rst pulsed in the 2nd WAIT cycle -> FSM in IDLE after reset, mem[2] unchanged, mem_data=0; with req still held, a fresh 5-cycle access then completes the store.
REQ-046 Store to 1036 immediately followed by a load from 1036 -> two 5-cycle accesses with no gap; wb_en=0 whenever ready=0; mem_data equals the stored value at the second DONE.
